// File: rtl/l1_trig_pkg.sv
// Record layout and beam FSM encoding shared by the L1 trigger scaler.
// The scaler field sits below the drop count, so it may use at most DROP_LSB bits.
package l1_trig_pkg;

  localparam int unsigned REC_W        = 128;
  localparam int unsigned SEQ_LSB      = 112;
  localparam int unsigned SEQ_W        = 16;
  localparam int unsigned DROP_LSB     = 104;
  localparam int unsigned DROP_W       = 8;
  localparam int unsigned SCAL_FIELD_W = DROP_LSB;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

  function automatic bit scal_fits(input int unsigned nbeams, input int unsigned bits);
    return (nbeams * bits) <= SCAL_FIELD_W;
  endfunction

endpackage

// File: rtl/l1_trigger_scaler_beam.sv
// Per-beam trigger qualifier: IDLE/HOLD holdoff FSM with a registered pulse output.
// accept_o is combinational so the scaler can count an accept in the same cycle.
module l1_beam_holdoff
  import l1_trig_pkg::*;
#(
  parameter int unsigned HOLDOFF_BITS = 8
) (
  input  logic                    aclk,
  input  logic                    reset_i,
  input  logic                    trig_i,
  input  logic                    mask_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic                    accept_o,
  output logic                    trig_o
);

  hold_state_e             state_q, state_d;
  logic [HOLDOFF_BITS-1:0] cnt_q, cnt_d;
  logic                    trig_q;

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= accept_o;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_i && !mask_i) begin
          accept_o = 1'b1;
          cnt_d    = holdoff_i;
          if (holdoff_i != '0) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Mask is deliberately not consulted here: the countdown always completes.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == HOLDOFF_BITS'(1)) state_d = ST_IDLE;
      end
    endcase
  end

  assign trig_o = trig_q;

endmodule

// File: rtl/l1_trigger_scaler.sv
// Qualifies per-beam L1 triggers, counts them over a fixed gate period and
// publishes one scaler record per period on a single-register AXI4-Stream master.
module l1_trigger_scaler
  import l1_trig_pkg::*;
#(
  parameter int unsigned NBEAMS        = 2,
  parameter int unsigned HOLDOFF_BITS  = 8,
  parameter int unsigned SCALER_BITS   = 16,
  parameter int unsigned PERIOD_CYCLES = 375000
) (
  input  logic                    aclk,
  input  logic                    reset_i,
  input  logic [NBEAMS-1:0]       trig_i,
  input  logic [NBEAMS-1:0]       mask_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic [NBEAMS-1:0]       trig_o,
  output logic [REC_W-1:0]        scal_tdata,
  output logic                    scal_tvalid,
  input  logic                    scal_tready
);

  localparam bit                SCAL_OK  = scal_fits(NBEAMS, SCALER_BITS);
  localparam int unsigned       PER_W    = $clog2(PERIOD_CYCLES);
  localparam logic [PER_W-1:0]  PER_LAST = PER_W'(PERIOD_CYCLES - 1);

  if (!SCAL_OK) begin : g_cfg_err
    $error("l1_trigger_scaler: NBEAMS*SCALER_BITS exceeds the record scaler field");
  end

  logic [NBEAMS-1:0]                  accept;
  logic [PER_W-1:0]                   period_q, period_d;
  logic [NBEAMS-1:0][SCALER_BITS-1:0] scal_q, scal_d, scal_inc;
  logic [SEQ_W-1:0]                   seq_q, seq_d;
  logic [DROP_W-1:0]                  drop_q, drop_d;
  logic [REC_W-1:0]                   rec, data_q, data_d;
  logic                               valid_q, valid_d;
  logic                               tc, load;

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    l1_beam_holdoff #(.HOLDOFF_BITS(HOLDOFF_BITS)) u_beam (
      .aclk      (aclk),
      .reset_i   (reset_i),
      .trig_i    (trig_i[b]),
      .mask_i    (mask_i[b]),
      .holdoff_i (holdoff_i),
      .accept_o  (accept[b]),
      .trig_o    (trig_o[b])
    );
  end

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      period_q <= '0;
      scal_q   <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      scal_q   <= scal_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    scal_inc = '0;
    scal_d   = '0;
    rec      = '0;
    tc       = (period_q == PER_LAST);
    period_d = tc ? '0 : period_q + 1'b1;
    seq_d    = tc ? seq_q + 1'b1 : seq_q;
    rec[SEQ_LSB +: SEQ_W]   = seq_q;
    rec[DROP_LSB +: DROP_W] = drop_q;
    // The record takes the post-increment value so a TC-cycle accept is included.
    for (int b = 0; b < NBEAMS; b++) begin
      scal_inc[b] = (accept[b] && (scal_q[b] != '1)) ? scal_q[b] + 1'b1 : scal_q[b];
      scal_d[b]   = tc ? '0 : scal_inc[b];
      rec[b*SCALER_BITS +: SCALER_BITS] = scal_inc[b];
    end
    load    = tc && (!valid_q || scal_tready);
    data_d  = load ? rec : data_q;
    valid_d = load || (valid_q && !scal_tready);
    if (load)                         drop_d = '0;
    else if (tc && (drop_q != '1))    drop_d = drop_q + 1'b1;
    else                              drop_d = drop_q;
  end

  assign scal_tdata  = data_q;
  assign scal_tvalid = valid_q;

endmodule

// File: tb/tb_l1_trigger_scaler.sv
// Self-checking bench for l1_trigger_scaler: scenario tasks with a record scoreboard.
// A second instance with a short period and 8-bit scalers exercises saturation.
module tb_l1_trigger_scaler;

  logic         aclk = 1'b0;
  logic         rst;
  logic [1:0]   trig, mask, trig_o;
  logic [7:0]   hold;
  logic [127:0] tdata;
  logic         tvalid, tready;

  logic         rst2;
  logic [1:0]   trig2, mask2, trig_o2;
  logic [7:0]   hold2;
  logic [127:0] tdata2;
  logic         tvalid2, tready2;

  int           total = 0;
  int           bad   = 0;
  int           cyc;
  logic [127:0] exp_q[$];

  always #5 aclk = ~aclk;

  always @(posedge aclk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  l1_trigger_scaler #(
    .NBEAMS(2), .HOLDOFF_BITS(8), .SCALER_BITS(16), .PERIOD_CYCLES(100)
  ) dut (
    .aclk(aclk), .reset_i(rst), .trig_i(trig), .mask_i(mask), .holdoff_i(hold),
    .trig_o(trig_o), .scal_tdata(tdata), .scal_tvalid(tvalid), .scal_tready(tready)
  );

  l1_trigger_scaler #(
    .NBEAMS(2), .HOLDOFF_BITS(8), .SCALER_BITS(8), .PERIOD_CYCLES(300)
  ) dut_sat (
    .aclk(aclk), .reset_i(rst2), .trig_i(trig2), .mask_i(mask2), .holdoff_i(hold2),
    .trig_o(trig_o2), .scal_tdata(tdata2), .scal_tvalid(tvalid2), .scal_tready(tready2)
  );

  function automatic logic [127:0] mk_rec(input int seq, input int drop,
                                          input int s0, input int s1, input int sb);
    logic [127:0] r;
    r = '0;
    r[127:112] = 16'(seq);
    r[111:104] = 8'(drop);
    r = r | 128'(s0) | (128'(s1) << sb);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; trig = '0; mask = '0; hold = '0; tready = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge aclk);
    rst = 1'b0;
  endtask

  task automatic wait_rec(input int limit, output logic [127:0] d, output bit ok);
    ok = 1'b0; d = '0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (tvalid && tready) begin
        d  = tdata;
        ok = 1'b1;
      end
      @(negedge aclk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (trig_o !== 2'b00) begin bad++; $display("FAIL reset_trig_o got=%b want=00", trig_o); end
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", tvalid); end
    total++; if (tdata !== '0) begin bad++; $display("FAIL reset_tdata got=%h want=0", tdata); end
  endtask

  task automatic test_holdoff();
    logic [1:0] exp_t; logic [127:0] d, e; bit ok;
    do_reset();
    hold = 8'd4;
    exp_q.push_back(mk_rec(0, 0, 4, 0, 16));
    for (int c = 0; c < 100; c++) begin
      exp_t = (c == 11 || c == 16 || c == 21 || c == 26) ? 2'b01 : 2'b00;
      total++;
      if (trig_o !== exp_t) begin bad++; $display("FAIL holdoff_pulse cyc=%0d got=%b want=%b", c, trig_o, exp_t); end
      trig = (c >= 10 && c < 30) ? 2'b01 : 2'b00;
      @(negedge aclk);
    end
    trig = '0;
    wait_rec(10, d, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL holdoff_record ok=%0d got=%h want=%h", ok, d, e); end
  endtask

  task automatic test_steady();
    logic [127:0] d, e; bit ok;
    do_reset();
    hold = 8'd0; trig = 2'b11;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk_rec(k, 0, 100, 100, 16));
    @(negedge aclk);
    total++; if (trig_o !== 2'b11) begin bad++; $display("FAIL steady_trig_o got=%b want=11", trig_o); end
    for (int k = 0; k < 3; k++) begin
      wait_rec(150, d, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || d !== e) begin bad++; $display("FAIL steady_record%0d ok=%0d got=%h want=%h", k, ok, d, e); end
    end
  endtask

  task automatic test_mask();
    logic [1:0] exp_t; logic [127:0] d, e; bit ok;
    do_reset();
    hold = 8'd3; trig = 2'b11;
    exp_q.push_back(mk_rec(0, 0, 25, 0, 16));
    for (int c = 0; c < 100; c++) begin
      exp_t = (c >= 1 && (c % 4) == 1) ? 2'b01 : 2'b00;
      total++;
      if (trig_o !== exp_t) begin bad++; $display("FAIL mask_pulse cyc=%0d got=%b want=%b", c, trig_o, exp_t); end
      // beam 0 is masked only while it sits in HOLD
      mask = ((c % 4) == 2) ? 2'b11 : 2'b10;
      @(negedge aclk);
    end
    wait_rec(10, d, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL mask_record ok=%0d got=%h want=%h", ok, d, e); end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, e; bit ok;
    do_reset();
    hold = 8'd0; trig = 2'b01; tready = 1'b0;
    exp_q.push_back(mk_rec(0, 0, 100, 0, 16));
    exp_q.push_back(mk_rec(3, 2, 100, 0, 16));
    for (int c = 0; c < 350; c++) begin
      if (c == 99) begin
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL bp_early_valid got=%b want=0", tvalid); end
      end
      if (c >= 100) begin
        total++;
        if ({tvalid, tdata} !== {1'b1, exp_q[0]}) begin
          bad++; $display("FAIL bp_hold cyc=%0d valid=%b got=%h want=%h", c, tvalid, tdata, exp_q[0]);
        end
      end
      @(negedge aclk);
    end
    tready = 1'b1;
    wait_rec(1, d, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL bp_first ok=%0d got=%h want=%h", ok, d, e); end
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL bp_drop_valid got=%b want=0", tvalid); end
    wait_rec(100, d, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL bp_next ok=%0d got=%h want=%h", ok, d, e); end
  endtask

  task automatic test_saturation();
    logic [127:0] e; bit ok;
    trig2 = 2'b11; mask2 = '0; hold2 = '0; tready2 = 1'b1;
    @(negedge aclk);
    rst2 = 1'b0;
    exp_q.push_back(mk_rec(0, 0, 255, 255, 8));
    exp_q.push_back(mk_rec(1, 0, 255, 255, 8));
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge aclk);
        if (tvalid2) begin
          ok = 1'b1;
          e  = exp_q.pop_front();
          total++;
          if (tdata2 !== e) begin bad++; $display("FAIL sat_record%0d got=%h want=%h", k, tdata2, e); end
        end
      end
      if (!ok) begin total++; bad++; $display("FAIL sat_timeout%0d got=no_record want=record", k); end
    end
    rst2 = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    logic [127:0] d, e; bit ok;
    do_reset();
    hold = 8'd20; trig = 2'b01; tready = 1'b0;
    repeat (148) @(negedge aclk);
    total++; if (trig_o !== 2'b01) begin bad++; $display("FAIL ar_pre_trig got=%b want=01", trig_o); end
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b want=1", tvalid); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({trig_o, tvalid, tdata} !== '0) begin
      bad++; $display("FAIL ar_outputs trig=%b valid=%b data=%h want=0", trig_o, tvalid, tdata);
    end
    repeat (2) @(negedge aclk);
    hold = 8'd0; trig = 2'b01; tready = 1'b1;
    rst = 1'b0;
    exp_q.push_back(mk_rec(0, 0, 100, 0, 16));
    wait_rec(150, d, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || d !== e) begin bad++; $display("FAIL ar_record ok=%0d got=%h want=%h", ok, d, e); end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    trig = '0; mask = '0; hold = '0; tready = 1'b1;
    trig2 = '0; mask2 = '0; hold2 = '0; tready2 = 1'b1;
    test_reset();
    test_holdoff();
    test_steady();
    test_mask();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timed out");
  end

endmodule
